// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG TCK burst generator.
package jtag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_e;

  localparam int MIN_PERIOD = 1;

endpackage

// File: rtl/jtag_phase_cnt.sv
// Phase counter shared by the TCK low and high phases; clears on clr_i, else counts up.
// tc_o flags the current count equals term_i; cnt_nxt_o exposes the next value for registered strobes.
module jtag_phase_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             ref_clk,
  input  logic             rstn,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] term_i,
  output logic [CNT_W-1:0] cnt_nxt_o,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign cnt_d     = clr_i ? '0 : cnt_q + 1'b1;
  assign cnt_nxt_o = cnt_d;
  assign tc_o      = (cnt_q == term_i);

  always_ff @(posedge ref_clk or negedge rstn) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/jtag_tck_burst_gen.sv
// JTAG TCK generator: counted bursts or free-run, programmable phases, clean stop.
// All outputs registered; no backpressure, start is ignored while busy.
module jtag_tck_burst_gen
  import jtag_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int LEN_W = 16
) (
  input  logic             ref_clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] tck_high_period,
  input  logic [CNT_W-1:0] tck_low_period,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             stop,
  output logic             tck,
  output logic             jtag_rd_en,
  output logic             jtag_wr_en,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] tck_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] lm1_q, lm1_d, hm1_q, hm1_d;
  logic [CNT_W-1:0] low_m1, high_m1, term, cnt_nxt;
  logic [LEN_W-1:0] len_q, len_d, tck_cnt_q, tck_cnt_d;
  logic             stop_q, stop_d, stop_any, fin, tc, clr;
  logic             tck_q, rd_q, wr_q, busy_q, done_q;

  // Phase lengths are kept as length-1 so a zero input clamps to one cycle.
  assign low_m1   = (tck_low_period  < CNT_W'(MIN_PERIOD)) ? '0 : tck_low_period  - CNT_W'(MIN_PERIOD);
  assign high_m1  = (tck_high_period < CNT_W'(MIN_PERIOD)) ? '0 : tck_high_period - CNT_W'(MIN_PERIOD);
  assign term     = (state_q == HIGH) ? hm1_q : lm1_q;
  assign stop_any = stop | stop_q;
  assign clr      = (state_d != state_q) || (state_d == IDLE);

  jtag_phase_cnt #(.CNT_W(CNT_W)) u_phase_cnt (
    .ref_clk   (ref_clk),
    .rstn      (rstn),
    .clr_i     (clr),
    .term_i    (term),
    .cnt_nxt_o (cnt_nxt),
    .tc_o      (tc)
  );

  always_comb begin
    state_d   = state_q;
    lm1_d     = lm1_q;
    hm1_d     = hm1_q;
    len_d     = len_q;
    tck_cnt_d = tck_cnt_q;
    stop_d    = stop_q;
    fin       = 1'b0;
    unique case (state_q)
      IDLE: begin
        stop_d = 1'b0;
        if (start) begin
          lm1_d     = low_m1;
          hm1_d     = high_m1;
          len_d     = burst_len;
          tck_cnt_d = '0;
          state_d   = LOW;
        end
      end
      LOW: begin
        // A stop seen before the rd_en cycle aborts without a rising edge.
        if (stop_any && !tc) begin
          state_d = IDLE;
          stop_d  = 1'b0;
          fin     = 1'b1;
        end else begin
          stop_d = stop_any;
          if (tc) state_d = HIGH;
        end
      end
      HIGH: begin
        stop_d = stop_any;
        if (tc) begin
          tck_cnt_d = tck_cnt_q + 1'b1;
          if (stop_any || ((len_q != '0) && (tck_cnt_d == len_q))) begin
            state_d = IDLE;
            stop_d  = 1'b0;
            fin     = 1'b1;
          end else begin
            state_d = LOW;
            lm1_d   = low_m1;
            hm1_d   = high_m1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      lm1_q     <= '0;
      hm1_q     <= '0;
      len_q     <= '0;
      tck_cnt_q <= '0;
      stop_q    <= 1'b0;
      tck_q     <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lm1_q     <= lm1_d;
      hm1_q     <= hm1_d;
      len_q     <= len_d;
      tck_cnt_q <= tck_cnt_d;
      stop_q    <= stop_d;
      // Strobes look ahead at the next phase count so they stay registered.
      tck_q     <= (state_d == HIGH);
      rd_q      <= (state_d == LOW)  && (cnt_nxt == lm1_d);
      wr_q      <= (state_d == HIGH) && (cnt_nxt == hm1_d);
      busy_q    <= (state_d != IDLE);
      done_q    <= fin;
    end
  end

  assign tck        = tck_q;
  assign jtag_rd_en = rd_q;
  assign jtag_wr_en = wr_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign tck_cnt    = tck_cnt_q;

endmodule

// File: tb/tb_jtag_tck_burst_gen.sv
// Directed self-checking bench for jtag_tck_burst_gen; step n means the cycle after edge E0+n.
module tb_jtag_tck_burst_gen;

  logic        ref_clk = 1'b0;
  logic        rstn;
  logic [15:0] tck_high_period, tck_low_period, burst_len;
  logic        start, stop;
  logic        tck, jtag_rd_en, jtag_wr_en, busy, done;
  logic [15:0] tck_cnt;
  logic [4:0]  obs;
  int          n_chk = 0;
  int          n_fail = 0;

  assign obs = {tck, jtag_rd_en, jtag_wr_en, busy, done};

  always #5 ref_clk = ~ref_clk;

  jtag_tck_burst_gen #(.CNT_W(16), .LEN_W(16)) dut (
    .ref_clk         (ref_clk),
    .rstn            (rstn),
    .tck_high_period (tck_high_period),
    .tck_low_period  (tck_low_period),
    .start           (start),
    .burst_len       (burst_len),
    .stop            (stop),
    .tck             (tck),
    .jtag_rd_en      (jtag_rd_en),
    .jtag_wr_en      (jtag_wr_en),
    .busy            (busy),
    .done            (done),
    .tck_cnt         (tck_cnt)
  );

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  // Expected {tck, rd_en, wr_en, busy, done} at step n; N=0 means free-run.
  function automatic logic [4:0] model(input int n, input int l, input int h, input int nb);
    int p, m;
    p = l + h;
    if (nb != 0 && n >= nb * p) return {4'b0000, n == nb * p};
    m = n % p;
    return {m >= l, m == l - 1, m == p - 1, 1'b1, 1'b0};
  endfunction

  function automatic logic [15:0] cnt_model(input int n, input int l, input int h, input int nb);
    int c;
    c = n / (l + h);
    if (nb != 0 && c > nb) c = nb;
    return 16'(c);
  endfunction

  task automatic test_reset();
    rstn = 1'b0; start = 1'b0; stop = 1'b0;
    tck_high_period = 16'd1; tck_low_period = 16'd1; burst_len = 16'd1;
    #3;
    n_chk++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL reset_outputs got %b expected 00000", obs); end
    n_chk++;
    if (tck_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_tck_cnt got %0d expected 0", tck_cnt); end
    step(); step();
    rstn = 1'b1;
    step();
    n_chk++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL idle_after_reset got %b expected 00000", obs); end
  endtask

  task automatic test_burst_basic();
    tck_low_period = 16'd3; tck_high_period = 16'd2; burst_len = 16'd4;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n <= 22; n++) begin
      n_chk++;
      if (obs !== model(n, 3, 2, 4)) begin
        n_fail++; $display("FAIL basic_wave step %0d got %b expected %b", n, obs, model(n, 3, 2, 4));
      end
      n_chk++;
      if (tck_cnt !== cnt_model(n, 3, 2, 4)) begin
        n_fail++; $display("FAIL basic_cnt step %0d got %0d expected %0d", n, tck_cnt, cnt_model(n, 3, 2, 4));
      end
      step();
    end
  endtask

  task automatic test_min_period();
    tck_low_period = 16'd0; tck_high_period = 16'd0; burst_len = 16'd3;
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    for (int n = 0; n <= 7; n++) begin
      n_chk++;
      if (obs !== model(n, 1, 1, 3)) begin
        n_fail++; $display("FAIL min_wave step %0d got %b expected %b", n, obs, model(n, 1, 1, 3));
      end
      n_chk++;
      if (tck_cnt !== cnt_model(n, 1, 1, 3)) begin
        n_fail++; $display("FAIL min_cnt step %0d got %0d expected %0d", n, tck_cnt, cnt_model(n, 1, 1, 3));
      end
      step();
    end
  endtask

  task automatic test_free_run_stop();
    tck_low_period = 16'd2; tck_high_period = 16'd2; burst_len = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n <= 26; n++) begin
      n_chk++;
      if (obs !== model(n, 2, 2, 6)) begin
        n_fail++; $display("FAIL freerun_wave step %0d got %b expected %b", n, obs, model(n, 2, 2, 6));
      end
      n_chk++;
      if (tck_cnt !== cnt_model(n, 2, 2, 6)) begin
        n_fail++; $display("FAIL freerun_cnt step %0d got %0d expected %0d", n, tck_cnt, cnt_model(n, 2, 2, 6));
      end
      if (n == 22) stop = 1'b1;
      step();
      stop = 1'b0;
    end
  endtask

  task automatic test_stop_low();
    tck_low_period = 16'd4; tck_high_period = 16'd1; burst_len = 16'd0;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n <= 6; n++) begin
      n_chk++;
      if (obs !== model(n, 4, 1, 0)) begin
        n_fail++; $display("FAIL stoplow_wave step %0d got %b expected %b", n, obs, model(n, 4, 1, 0));
      end
      if (n == 6) stop = 1'b1;
      step();
      stop = 1'b0;
    end
    n_chk++;
    if (obs !== 5'b00001) begin n_fail++; $display("FAIL stoplow_abort got %b expected 00001", obs); end
    n_chk++;
    if (tck_cnt !== 16'd1) begin n_fail++; $display("FAIL stoplow_cnt got %0d expected 1", tck_cnt); end
    step();
    n_chk++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL stoplow_after got %b expected 00000", obs); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp;
    logic [15:0] exp_cnt;
    int          m;
    tck_low_period = 16'd2; tck_high_period = 16'd2; burst_len = 16'd3;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n <= 15; n++) begin
      m = n - 8;
      if (n < 8) exp = model(n, 2, 2, 0);
      else       exp = {m == 5 || m == 6, m == 4, m == 6, m < 7, m == 7};
      exp_cnt = (n < 4) ? 16'd0 : (n < 8) ? 16'd1 : (n < 15) ? 16'd2 : 16'd3;
      n_chk++;
      if (obs !== exp) begin n_fail++; $display("FAIL change_wave step %0d got %b expected %b", n, obs, exp); end
      n_chk++;
      if (tck_cnt !== exp_cnt) begin n_fail++; $display("FAIL change_cnt step %0d got %0d expected %0d", n, tck_cnt, exp_cnt); end
      if (n == 6) tck_low_period = 16'd5;
      if (n == 15) begin
        tck_low_period = 16'd1; tck_high_period = 16'd2; burst_len = 16'd2; start = 1'b1;
      end
      step();
      start = 1'b0;
    end
    for (int n = 0; n <= 7; n++) begin
      n_chk++;
      if (obs !== model(n, 1, 2, 2)) begin
        n_fail++; $display("FAIL b2b_wave step %0d got %b expected %b", n, obs, model(n, 1, 2, 2));
      end
      n_chk++;
      if (tck_cnt !== cnt_model(n, 1, 2, 2)) begin
        n_fail++; $display("FAIL b2b_cnt step %0d got %0d expected %0d", n, tck_cnt, cnt_model(n, 1, 2, 2));
      end
      step();
    end
  endtask

  task automatic test_async_reset();
    tck_low_period = 16'd2; tck_high_period = 16'd3; burst_len = 16'd5;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n <= 8; n++) begin
      n_chk++;
      if (obs !== model(n, 2, 3, 5)) begin
        n_fail++; $display("FAIL arst_pre step %0d got %b expected %b", n, obs, model(n, 2, 3, 5));
      end
      if (n < 8) step();
    end
    #2 rstn = 1'b0;
    #1;
    n_chk++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL arst_immediate got %b expected 00000", obs); end
    n_chk++;
    if (tck_cnt !== 16'd0) begin n_fail++; $display("FAIL arst_cnt got %0d expected 0", tck_cnt); end
    step();
    rstn = 1'b1;
    step();
    n_chk++;
    if (obs !== 5'b00000) begin n_fail++; $display("FAIL arst_no_done got %b expected 00000", obs); end
    tck_low_period = 16'd1; tck_high_period = 16'd2; burst_len = 16'd2;
    start = 1'b1; step(); start = 1'b0;
    for (int n = 0; n <= 7; n++) begin
      n_chk++;
      if (obs !== model(n, 1, 2, 2)) begin
        n_fail++; $display("FAIL arst_restart step %0d got %b expected %b", n, obs, model(n, 1, 2, 2));
      end
      n_chk++;
      if (tck_cnt !== cnt_model(n, 1, 2, 2)) begin
        n_fail++; $display("FAIL arst_restart_cnt step %0d got %0d expected %0d", n, tck_cnt, cnt_model(n, 1, 2, 2));
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_burst_basic();
    test_min_period();
    test_free_run_stop();
    test_stop_low();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tck_burst_gen.md
# jtag_tck_burst_gen

Parametrised JTAG TCK generator with burst control. It produces TCK from ref_clk with programmable high and low phase lengths. It can emit either a counted burst of TCK periods or a free-running clock, and it stops on request at a clean boundary. It sits between the JTAG shift/TAP sequencer and the pad. It emits one-cycle rd_en/wr_en strobes that tell the sequencer when to drive TDI/TMS and when to sample TDO.

## Interface
Parameters:
- CNT_W, 16, width of the phase-length inputs and of the phase counter
- LEN_W, 16, width of burst_len and tck_cnt

Ports:
- ref_clk  in  1  reference clock; all logic is on its rising edge
- rstn  in  1  reset, asynchronous, active-low
- tck_high_period  in  CNT_W  TCK high phase length in ref_clk cycles; 0 is treated as 1
- tck_low_period  in  CNT_W  TCK low phase length in ref_clk cycles; 0 is treated as 1
- start  in  1  one-cycle request to begin a burst; ignored while busy
- burst_len  in  LEN_W  number of TCK periods to emit; 0 selects free-run
- stop  in  1  one-cycle request to end the current burst or free-run
- tck  out  1  generated TCK
- jtag_rd_en  out  1  one-cycle strobe in the ref_clk cycle immediately before each TCK rising edge (sequencer drives data)
- jtag_wr_en  out  1  one-cycle strobe in the ref_clk cycle immediately before each TCK falling edge (sequencer latches data)
- busy  out  1  high from start acceptance until termination
- done  out  1  one-cycle pulse after termination
- tck_cnt  out  LEN_W  completed TCK periods (falling edges) in the current or last burst; wraps modulo 2^LEN_W

## Operation
- States: IDLE, LOW, HIGH.
- Effective periods: L = max(tck_low_period, 1) and H = max(tck_high_period, 1). They are latched at start acceptance and again at every falling-edge boundary, so a change takes effect from the next full period.
- IDLE:
  - tck=0, no strobes.
  - start sampled high: latch L, H and burst_len; clear tck_cnt; set busy; enter LOW with the phase counter at 0.
- LOW:
  - tck=0 for L cycles.
  - jtag_rd_en is high in the last LOW cycle.
  - TCK rises on the edge ending that cycle, and the block enters HIGH.
- HIGH:
  - tck=1 for H cycles.
  - jtag_wr_en is high in the last HIGH cycle.
  - TCK falls on the edge ending that cycle, and tck_cnt increments.
  - If burst_len≠0 and tck_cnt reaches burst_len: go to IDLE, busy drops on the same edge, done=1 for the next cycle.
  - Otherwise re-enter LOW with freshly latched L and H.
- stop while busy:
  - In LOW, before the rd_en cycle: abort on the next edge. No rd_en is issued, tck stays 0, tck_cnt is unchanged, busy drops and done pulses.
  - In the rd_en cycle or during HIGH: the period completes through its falling edge (wr_en issued, tck_cnt increments), then termination as above.
  - Once asserted, stop is remembered until termination.
- stop while IDLE is ignored. start together with stop in IDLE: start is accepted and stop is ignored.
- start during the done cycle (busy already 0) is accepted, giving back-to-back bursts with tck held low throughout.
- Arithmetic:
  - The phase counter is CNT_W bits, and the compare uses L-1 and H-1, so no overflow occurs at L = 2^CNT_W-1.
  - tck_cnt wraps in free-run.
  - The burst_len compare is on equality.

## Timing
- Reset values: tck=0, jtag_rd_en=0, jtag_wr_en=0, busy=0, done=0, tck_cnt=0, state IDLE.
- All outputs are registered.
- Take start sampled at edge E0:
  - busy=1 after E0.
  - TCK period k (k=0,1,…) rises at E0+L+k(L+H) and falls at E0+(k+1)(L+H).
  - jtag_rd_en is high in the cycle ending at each rising edge; jtag_wr_en is high in the cycle ending at each falling edge.
- N-period burst: the last falling edge is at E0+N(L+H), busy=0 from that edge, and done is high for exactly one cycle after it.
- The minimum period is 2 cycles (L=H=1). In that case rd_en and wr_en alternate every cycle and never overlap.
- Asynchronous reset mid-burst forces all reset values immediately, with no done pulse.

## Structure
- Shared package jtag_pkg: state enum (IDLE, LOW, HIGH) and the MIN_PERIOD=1 constant.
- One natural sub-module, jtag_phase_cnt: a CNT_W-bit phase counter with load/terminal-count output. It is reused by both phases.
- Top-level contents: FSM, period latches, burst counter, stop flag.

## Test plan
- L=3, H=2, burst_len=4, start at E0 -> rises at E0+3/8/13/18, falls at E0+5/10/15/20; done high one cycle after E0+20; tck_cnt=4.
- Periods 0/0, burst_len=3 -> clamped to 1/1; 6-cycle burst; rd_en and wr_en alternate every cycle; done after E0+6.
- burst_len=0 free-run with L=2, H=2; stop pulsed in a HIGH cycle after 5 falls -> completes the 6th fall, tck_cnt=6, done pulses, tck=0.
- Free-run with L=4; stop in the 2nd LOW cycle -> no rd_en, tck stays 0, busy drops next edge, tck_cnt unchanged.
- L changed from 2 to 5 mid-HIGH of period 1 -> period 1 unchanged; period 2 low phase lasts 5 cycles. A start during the done cycle is accepted for back-to-back bursts.
- rstn asserted mid-HIGH of a burst -> tck, strobes, busy and tck_cnt are 0 immediately; no done; a later start restarts cleanly.
